// File: rtl/req_ack_pkg.sv
// Shared types and constants for the req/ack responder.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int unsigned REQ_ACK_DEFAULT_DELAY = 32'd3;

endpackage

// File: rtl/req_ack_if.sv
// Single-bit request/acknowledge handshake wires, shared by requester, responder and checker.
interface req_ack_if;

  logic req;
  logic ack;

  modport master  (output req, input  ack);
  modport slave   (input  req, output ack);
  modport monitor (input  req, input  ack);

endinterface

// File: rtl/req_ack.sv
// Handshake responder: answers a held req with a one-cycle ack pulse ACK_DELAY edges
// after req is first sampled high.
module req_ack
  import req_ack_pkg::*;
#(
  parameter int unsigned ACK_DELAY = REQ_ACK_DEFAULT_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  req_ack_if.slave   hs
);

  localparam int unsigned      CNT_W    = $clog2(ACK_DELAY + 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_DELAY - 32'd1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;

  // The counter holds the number of further WAIT edges before ack; ACK is entered at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_ZERO;
    ack_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs.req) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!hs.req) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ACK: begin
        if (hs.req) begin
          state_d = RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      RELEASE: begin
        if (hs.req) begin
          state_d = RELEASE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
    end
  end

  assign hs.ack = ack_q;

endmodule

// File: tb/tb_req_ack.sv
// Self-checking bench: directed and random req/reset stimulus driven into a default-delay
// and a single-edge-delay responder, compared every cycle against a run-length model.
module tb_req_ack;
  import req_ack_pkg::*;

  localparam int D3 = REQ_ACK_DEFAULT_DELAY;
  localparam int D1 = 1;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cycle;
  int   run;

  req_ack_if bus3 ();
  req_ack_if bus1 ();

  req_ack #(.ACK_DELAY(D3)) dut3 (.clk(clk), .reset(reset), .hs(bus3.slave));
  req_ack #(.ACK_DELAY(D1)) dut1 (.clk(clk), .reset(reset), .hs(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: observed %0b expected %0b", tag, cycle, obs, exp);
    end
  endtask

  // An ack is due exactly when req has been sampled high on D+1 consecutive
  // non-reset edges; a low sample or a reset edge restarts the run.
  task automatic step(input logic r, input logic rs);
    reset    = rs;
    bus3.req = r;
    bus1.req = r;
    @(posedge clk);
    #1;
    cycle++;
    if (rs || !r) run = 0;
    else if (run < 100000) run++;
    check_eq("ack_d3", bus3.ack, (run == D3 + 1) ? 1'b1 : 1'b0);
    check_eq("ack_d1", bus1.ack, (run == D1 + 1) ? 1'b1 : 1'b0);
  endtask

  task automatic hold(input logic r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cycle    = 0;
    run      = 0;
    reset    = 1'b1;
    bus3.req = 1'b0;
    bus1.req = 1'b0;

    // reset with req high, then req kept high after reset releases
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 6);
    hold(1'b0, 2);

    // nominal handshake followed by a clean drop
    hold(1'b1, 5);
    hold(1'b0, 3);

    // abort after two edges, then a fresh request
    hold(1'b1, 2);
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 1);

    // stuck req: a single ack only; re-raise after a drop gives a second one
    hold(1'b1, 20);
    hold(1'b0, 1);
    hold(1'b1, 6);
    hold(1'b0, 1);

    // back-to-back transactions with a one-edge gap
    for (int t = 0; t < 4; t++) begin
      hold(1'b1, 4);
      hold(1'b0, 1);
    end

    // reset in the middle of WAIT, then a new request
    hold(1'b1, 2);
    step(1'b1, 1'b1);
    hold(1'b1, 5);
    hold(1'b0, 2);

    // random req segments with occasional resets
    for (int s = 0; s < 120; s++) begin
      int   len;
      logic lvl;
      len = int'($urandom_range(1, 7));
      lvl = logic'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        step(lvl, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
